// File: rtl/read_reorder_buffer.sv
// Read reorder buffer: allocates TIDs in request order, accepts fill data out of
// order from the hit path and the miss handler, and returns single-beat AXI R
// responses strictly in allocation order.
module read_reorder_buffer #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH  = 2,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          alloc_valid_i,
    output logic                          alloc_ready_o,
    input  logic [ID_WIDTH-1:0]           alloc_id_i,
    output logic [TID_WIDTH-1:0]          alloc_tid_o,

    input  logic                          hit_write_en_i,
    output logic                          hit_full_o,
    input  logic [DATA_WIDTH+TID_WIDTH-1:0] hit_wdata_i,

    input  logic                          miss_write_en_i,
    output logic                          miss_full_o,
    input  logic [DATA_WIDTH+TID_WIDTH-1:0] miss_wdata_i,

    output logic                          rvalid_o,
    input  logic                          rready_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [ID_WIDTH-1:0]           rid_o,
    output logic [1:0]                    rresp_o,
    output logic                          rlast_o,

    output logic                          err_o
);

    localparam int unsigned DEPTH = 2 ** TID_WIDTH;
    localparam logic [TID_WIDTH:0] FULL_COUNT = (TID_WIDTH + 1)'(DEPTH);

    // Pointers and occupancy
    logic [TID_WIDTH-1:0] head_q, tail_q;
    logic [TID_WIDTH:0]   count_q;

    // Per-entry state
    logic [DEPTH-1:0]      alloc_q, alloc_d;
    logic [DEPTH-1:0]      dvld_q, dvld_d;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ID_WIDTH-1:0]   id_mem [DEPTH];

    // Staging registers
    logic                  hit_vld_q, miss_vld_q;
    logic [TID_WIDTH-1:0]  hit_tid_q, miss_tid_q;
    logic [DATA_WIDTH-1:0] hit_data_q, miss_data_q;

    // 1 = miss was served last, so hit wins the next tie
    logic last_miss_q;
    logic err_q;

    logic                  alloc_fire, retire;
    logic                  hit_capture, miss_capture;
    logic                  drain_hit, drain_miss, drain_any;
    logic [TID_WIDTH-1:0]  drain_tid;
    logic [DATA_WIDTH-1:0] drain_data;
    logic                  drain_err, write_err;

    assign alloc_ready_o = (count_q != FULL_COUNT);
    assign alloc_tid_o   = tail_q;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o;

    assign rvalid_o = alloc_q[head_q] && dvld_q[head_q];
    assign rdata_o  = data_mem[head_q];
    assign rid_o    = id_mem[head_q];
    assign rresp_o  = 2'b00;
    assign rlast_o  = 1'b1;
    assign retire   = rvalid_o && rready_i;

    assign hit_full_o  = hit_vld_q;
    assign miss_full_o = miss_vld_q;
    assign err_o       = err_q;

    // Staging capture, round-robin drain selection and error detection
    always_comb begin
        hit_capture  = hit_write_en_i && !hit_vld_q;
        miss_capture = miss_write_en_i && !miss_vld_q;
        drain_hit    = hit_vld_q && (!miss_vld_q || last_miss_q);
        drain_miss   = miss_vld_q && !drain_hit;
        drain_any    = drain_hit || drain_miss;
        drain_tid    = drain_hit ? hit_tid_q : miss_tid_q;
        drain_data   = drain_hit ? hit_data_q : miss_data_q;
        drain_err    = drain_any && (!alloc_q[drain_tid] || dvld_q[drain_tid]);
        write_err    = (hit_write_en_i && hit_vld_q) || (miss_write_en_i && miss_vld_q);
    end

    // Next-state of per-entry alloc/data-valid bits
    always_comb begin
        alloc_d = alloc_q;
        dvld_d  = dvld_q;
        if (drain_any) begin
            dvld_d[drain_tid] = 1'b1;
        end
        if (alloc_fire) begin
            alloc_d[tail_q] = 1'b1;
            dvld_d[tail_q]  = 1'b0;
        end
        if (retire) begin
            alloc_d[head_q] = 1'b0;
            dvld_d[head_q]  = 1'b0;
        end
    end

    // Control state: pointers, count, entry flags, staging, arbitration, error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            alloc_q     <= '0;
            dvld_q      <= '0;
            hit_vld_q   <= 1'b0;
            miss_vld_q  <= 1'b0;
            last_miss_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            alloc_q <= alloc_d;
            dvld_q  <= dvld_d;
            if (alloc_fire) begin
                tail_q <= tail_q + TID_WIDTH'(1);
            end
            if (retire) begin
                head_q <= head_q + TID_WIDTH'(1);
            end
            unique case ({alloc_fire, retire})
                2'b10:   count_q <= count_q + (TID_WIDTH + 1)'(1);
                2'b01:   count_q <= count_q - (TID_WIDTH + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (hit_capture) begin
                hit_vld_q <= 1'b1;
            end else if (drain_hit) begin
                hit_vld_q <= 1'b0;
            end
            if (miss_capture) begin
                miss_vld_q <= 1'b1;
            end else if (drain_miss) begin
                miss_vld_q <= 1'b0;
            end
            if (drain_hit) begin
                last_miss_q <= 1'b0;
            end else if (drain_miss) begin
                last_miss_q <= 1'b1;
            end
            if (drain_err || write_err) begin
                err_q <= 1'b1;
            end
        end
    end

    // Datapath storage: staging payloads and entry memories (no reset needed)
    always_ff @(posedge clk) begin
        if (hit_capture) begin
            hit_tid_q  <= hit_wdata_i[DATA_WIDTH +: TID_WIDTH];
            hit_data_q <= hit_wdata_i[DATA_WIDTH-1:0];
        end
        if (miss_capture) begin
            miss_tid_q  <= miss_wdata_i[DATA_WIDTH +: TID_WIDTH];
            miss_data_q <= miss_wdata_i[DATA_WIDTH-1:0];
        end
        if (drain_any) begin
            data_mem[drain_tid] <= drain_data;
        end
        if (alloc_fire) begin
            id_mem[tail_q] <= alloc_id_i;
        end
    end

endmodule

// File: tb/tb_read_reorder_buffer.sv
// Bench for read_reorder_buffer: scoreboard of expected R beats in allocation
// order, plus directed checks of latency, arbitration, stalls, errors and reset.
module tb_read_reorder_buffer;

    localparam int TW = 2;
    localparam int DW = 32;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid_i = 1'b0;
    logic          alloc_ready_o;
    logic [IW-1:0] alloc_id_i = '0;
    logic [TW-1:0] alloc_tid_o;
    logic          hit_write_en_i = 1'b0;
    logic          hit_full_o;
    logic [DW+TW-1:0] hit_wdata_i = '0;
    logic          miss_write_en_i = 1'b0;
    logic          miss_full_o;
    logic [DW+TW-1:0] miss_wdata_i = '0;
    logic          rvalid_o;
    logic          rready_i = 1'b1;
    logic [DW-1:0] rdata_o;
    logic [IW-1:0] rid_o;
    logic [1:0]    rresp_o;
    logic          rlast_o;
    logic          err_o;

    read_reorder_buffer #(
        .DATA_WIDTH(DW),
        .TID_WIDTH (TW),
        .ID_WIDTH  (IW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alloc_valid_i  (alloc_valid_i),
        .alloc_ready_o  (alloc_ready_o),
        .alloc_id_i     (alloc_id_i),
        .alloc_tid_o    (alloc_tid_o),
        .hit_write_en_i (hit_write_en_i),
        .hit_full_o     (hit_full_o),
        .hit_wdata_i    (hit_wdata_i),
        .miss_write_en_i(miss_write_en_i),
        .miss_full_o    (miss_full_o),
        .miss_wdata_i   (miss_wdata_i),
        .rvalid_o       (rvalid_o),
        .rready_i       (rready_i),
        .rdata_o        (rdata_o),
        .rid_o          (rid_o),
        .rresp_o        (rresp_o),
        .rlast_o        (rlast_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         sb[$];
    int            n_total = 0;
    int            n_bad = 0;
    logic [TW-1:0] exp_tail = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        alloc_valid_i = 1'b0;
        hit_write_en_i = 1'b0;
        miss_write_en_i = 1'b0;
        step();
        rst_n = 1'b1;
        sb.delete();
        exp_tail = '0;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_alloc_ready", 64'(alloc_ready_o), 64'd1);
        check_eq("rst_alloc_tid", 64'(alloc_tid_o), 64'd0);
        check_eq("rst_hit_full", 64'(hit_full_o), 64'd0);
        check_eq("rst_miss_full", 64'(miss_full_o), 64'd0);
        check_eq("rst_rvalid", 64'(rvalid_o), 64'd0);
        check_eq("rst_err", 64'(err_o), 64'd0);
    endtask

    task automatic do_alloc(input logic [IW-1:0] id, input logic [DW-1:0] data);
        beat_t b;
        alloc_valid_i = 1'b1;
        alloc_id_i = id;
        check_eq("alloc_ready", 64'(alloc_ready_o), 64'd1);
        check_eq("alloc_tid", 64'(alloc_tid_o), 64'(exp_tail));
        b.id = id;
        b.data = data;
        sb.push_back(b);
        step();
        alloc_valid_i = 1'b0;
        exp_tail = exp_tail + 1'b1;
    endtask

    task automatic miss_wr(input logic [TW-1:0] tid, input logic [DW-1:0] data);
        miss_write_en_i = 1'b1;
        miss_wdata_i = {tid, data};
        step();
        miss_write_en_i = 1'b0;
    endtask

    task automatic wait_empty();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: every accepted R beat must match the oldest expected beat
    always @(negedge clk) begin
        if (rst_n && rvalid_o && rready_i) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_beat", 64'(rid_o), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check_eq("sb_rid", 64'(rid_o), 64'(e.id));
                check_eq("sb_rdata", 64'(rdata_o), 64'(e.data));
                check_eq("sb_rlast", 64'(rlast_o), 64'd1);
                check_eq("sb_rresp", 64'(rresp_o), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0] t;
        logic [TW-1:0] order [4];

        // 1: minimum write-to-R latency
        do_reset();
        check_reset_vals();
        do_alloc(4'd3, 32'hA5A5_A5A5);
        miss_wr(2'd0, 32'hA5A5_A5A5);
        check_eq("t1_miss_full", 64'(miss_full_o), 64'd1);
        check_eq("t1_rvalid_early", 64'(rvalid_o), 64'd0);
        step();
        check_eq("t1_rvalid", 64'(rvalid_o), 64'd1);
        check_eq("t1_rdata", 64'(rdata_o), 64'hA5A5_A5A5);
        check_eq("t1_rid", 64'(rid_o), 64'd3);
        step();
        check_eq("t1_rvalid_after", 64'(rvalid_o), 64'd0);

        // 2: fill the buffer, write out of order, read in order
        do_reset();
        rready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_alloc(IW'(i + 1), 32'h1000_0000 + i);
        end
        check_eq("t2_full_ready", 64'(alloc_ready_o), 64'd0);
        order[0] = 2'd3;
        order[1] = 2'd1;
        order[2] = 2'd2;
        order[3] = 2'd0;
        for (int i = 0; i < 4; i++) begin
            miss_wr(order[i], 32'h1000_0000 + 32'(order[i]));
            step();
        end
        step();
        check_eq("t2_rvalid", 64'(rvalid_o), 64'd1);
        check_eq("t2_rid_head", 64'(rid_o), 64'd1);
        check_eq("t2_still_full", 64'(alloc_ready_o), 64'd0);
        rready_i = 1'b1;
        step();
        check_eq("t2_ready_after_retire", 64'(alloc_ready_o), 64'd1);
        wait_empty();

        // 3: simultaneous hit and miss writes, hit drains first
        do_alloc(4'd5, 32'h3000_0000);
        do_alloc(4'd6, 32'h3000_0001);
        do_alloc(4'd7, 32'h3000_0002);
        hit_write_en_i = 1'b1;
        hit_wdata_i = {2'd1, 32'h3000_0001};
        miss_write_en_i = 1'b1;
        miss_wdata_i = {2'd2, 32'h3000_0002};
        step();
        hit_write_en_i = 1'b0;
        miss_write_en_i = 1'b0;
        check_eq("t3_hit_full", 64'(hit_full_o), 64'd1);
        check_eq("t3_miss_full", 64'(miss_full_o), 64'd1);
        step();
        check_eq("t3_hit_drained", 64'(hit_full_o), 64'd0);
        check_eq("t3_miss_held", 64'(miss_full_o), 64'd1);
        step();
        check_eq("t3_miss_drained", 64'(miss_full_o), 64'd0);
        miss_wr(2'd0, 32'h3000_0000);
        wait_empty();
        check_eq("t3_err", 64'(err_o), 64'd0);

        // 4: backpressure holds the head beat stable
        do_alloc(4'd8, 32'hDEAD_BEEF);
        rready_i = 1'b0;
        miss_wr(2'd3, 32'hDEAD_BEEF);
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("t4_rvalid", 64'(rvalid_o), 64'd1);
            check_eq("t4_rdata", 64'(rdata_o), 64'hDEAD_BEEF);
            check_eq("t4_rid", 64'(rid_o), 64'd8);
            check_eq("t4_tid", 64'(alloc_tid_o), 64'(exp_tail));
            step();
        end
        rready_i = 1'b1;
        wait_empty();

        // 5: protocol errors are sticky
        check_eq("t5_err_clear", 64'(err_o), 64'd0);
        miss_wr(2'd2, 32'h0BAD_0BAD);
        step();
        check_eq("t5_err_unalloc", 64'(err_o), 64'd1);
        do_reset();
        check_eq("t5_err_reset", 64'(err_o), 64'd0);
        do_alloc(4'd9, 32'h55AA_55AA);
        miss_wr(2'd0, 32'h55AA_55AA);
        miss_wr(2'd0, 32'hBADB_AD00);
        check_eq("t5_err_overrun", 64'(err_o), 64'd1);
        wait_empty();
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("t5_err_sticky", 64'(err_o), 64'd1);
        end

        // 6: pointer wrap, then reset with pending entries
        do_reset();
        check_eq("t6_err_clear", 64'(err_o), 64'd0);
        for (int r = 0; r < 10; r++) begin
            t = exp_tail;
            do_alloc(IW'(r), 32'h6000_0000 + r);
            miss_wr(t, 32'h6000_0000 + r);
            wait_empty();
        end
        rready_i = 1'b0;
        t = exp_tail;
        do_alloc(4'hA, 32'h7000_000A);
        do_alloc(4'hB, 32'h7000_000B);
        miss_wr(t, 32'h7000_000A);
        step();
        check_eq("t6_pending", 64'(rvalid_o), 64'd1);
        do_reset();
        check_reset_vals();
        rready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check_eq("t6_no_stale", 64'(rvalid_o), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/read_reorder_buffer.md
# read_reorder_buffer

- Per-TID read reorder buffer (ROB) between the cache read paths and the AXI R channel.
- Allocates a transaction ID (TID) in request order.
- Accepts fill data out of order from two producers: the hit path and the read-miss handler, which sends {tid, data}.
- Returns data on AXI R strictly in allocation order.

## Interface
Parameters:
- DATA_WIDTH, `AXI_DATA_WIDTH, data beat width.
- TID_WIDTH, `TID_WIDTH, TID width. DEPTH = 2**TID_WIDTH entries.
- ID_WIDTH, `AXI_ID_WIDTH, AXI ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- alloc_valid_i  in  1  request-side allocation request.
- alloc_ready_o  out  1  entry available (count < DEPTH).
- alloc_id_i  in  ID_WIDTH  AXI ARID stored with the entry.
- alloc_tid_o  out  TID_WIDTH  TID granted (current tail).
- hit_write_en_i  in  1  hit-path write strobe.
- hit_full_o  out  1  hit staging register occupied.
- hit_wdata_i  in  DATA_WIDTH+TID_WIDTH  {tid, data}, tid in MSBs.
- miss_write_en_i  in  1  miss-handler write strobe.
- miss_full_o  out  1  miss staging register occupied.
- miss_wdata_i  in  DATA_WIDTH+TID_WIDTH  {tid, data}, tid in MSBs.
- rvalid_o  out  1  AXI R valid.
- rready_i  in  1  AXI R ready.
- rdata_o  out  DATA_WIDTH  read data.
- rid_o  out  ID_WIDTH  stored ARID.
- rresp_o  out  2  always 2'b00.
- rlast_o  out  1  always 1 (single-beat).
- err_o  out  1  sticky protocol error.

## Operation
State:
- head, tail: TID_WIDTH pointers that wrap naturally mod DEPTH.
- count: TID_WIDTH+1 bits.
- Per entry: alloc bit, data-valid bit, ID, data.
- Two staging registers (hit, miss), each holding {vld, tid, data}.

Allocation:
- alloc fires on alloc_valid_i && alloc_ready_o.
- On fire: set alloc[tail], store ID, clear data-valid[tail], increment tail.

Write capture:
- write_en with its full_o=0 loads that port's staging register.
- write_en while full_o=1 is ignored and sets err_o.
- full_o is the staging vld flag, driven from the register.

Drain (one storage write per cycle):
- Only one staging register holds data: drain it.
- Both hold data: drain round-robin, alternating via a last-served bit. Reset value of last-served = miss, so hit drains first.
- Drain writes data[tid] and sets data-valid[tid]; the staging vld clears the same edge.
- A drain to a tid with alloc=0 or data-valid=1 sets err_o. Data is still written.

Retire:
- rvalid_o = alloc[head] && data-valid[head]; rdata_o, rid_o come from entry head.
- On rvalid_o && rready_i: clear alloc and data-valid, increment head.
- rdata/rid are held stable while rvalid_o && !rready_i.

Count:
- +1 on alloc fire, -1 on retire, unchanged when both or neither occur.

## Timing
Reset values (rst_n low at a clk edge):
- head, tail, count = 0; all alloc and data-valid bits = 0; staging vld = 0.
- alloc_ready_o=1, alloc_tid_o=0, hit_full_o=0, miss_full_o=0, rvalid_o=0, err_o=0.
- Reset mid-operation discards all entries and staged data. No R beat is issued for them.

Latency:
- Allocation is combinational grant; alloc_tid_o valid in the same cycle.
- write_en at edge N: full_o=1 during cycle N+1, drain at edge N+1 at the earliest.
- rvalid_o for the head entry rises in cycle N+2. Minimum write-to-R latency is 2 cycles.
- full_o stays asserted an extra cycle when it loses round-robin.

Boundaries and simultaneous events:
- count==DEPTH: alloc_ready_o=0.
- Retire and alloc in the same cycle at full: alloc_ready_o is based on the registered count, so no alloc is taken in that cycle.
- Alloc into the entry retiring in the same cycle is impossible: tail==head only when count is 0 or DEPTH.
- Hit and miss writes in the same cycle to distinct tids: both captured, drained on consecutive edges.
- A drain to an entry not at head leaves it buffered until head reaches it, so no R beats go out of order.
- Pointer wrap DEPTH-1 -> 0 needs no special casing.

## Test plan
Bench parameters: TID_WIDTH=2, DATA_WIDTH=32, ID_WIDTH=4.
1. Reset, then alloc ID 3 (tid 0), miss write {0, 0xA5A5A5A5} at edge N -> miss_full_o=1 in N+1, rvalid_o=1 in N+2 with rdata 0xA5A5A5A5, rid 3, rlast 1, rresp 0.
2. Alloc tids 0-3 (IDs 1-4) -> alloc_ready_o=0 after the 4th. Writes arrive in order 3,1,2,0 -> R beats return IDs 1,2,3,4 in order. alloc_ready_o=1 after the first retire.
3. Hit write tid 1 and miss write tid 2 in the same cycle -> both full_o=1. Hit drains first, miss_full_o held one extra cycle. No data lost.
4. rready_i=0 for 5 cycles with rvalid_o=1 -> rdata_o/rid_o stable throughout, count unchanged.
5. Miss write to an unallocated tid, and write_en while miss_full_o=1 -> err_o=1 and stays 1 until reset.
6. Run 10 alloc/retire rounds to wrap pointers, then assert rst_n=0 with 2 pending entries -> all outputs at reset values next cycle, no stale R beat afterwards.
